// File: rtl/one_hot_pulse_decoder_if.sv
// Handshake and decoded-line bundle for one_hot_pulse_decoder.
// master = code source / line consumer, slave = the decoder.
interface one_hot_pulse_decoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_code;
   logic [15:0] out;
   logic        out_valid;
   logic        busy;

   modport master (
      output in_valid,
      output in_code,
      input  in_ready,
      input  out,
      input  out_valid,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  in_code,
      output in_ready,
      output out,
      output out_valid,
      output busy
   );
endinterface

// File: rtl/one_hot_pulse_decoder.sv
// Sequential 4-to-16 decoder: holds out[code] for HOLD_CYCLES, then one dead cycle.
// Define DECODER_FIFO_EN to add a 2-entry input FIFO with registered in_ready.
module one_hot_pulse_decoder #(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   one_hot_pulse_decoder_if.slave  bus,
   output logic [1:0]              state_dbg
);

   // Handshake: a code transfers on a rising edge where in_valid && in_ready;
   // in_code is sampled only then, and in_valid without in_ready has no effect.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LOAD = 8'(HOLD_CYCLES - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [15:0] out_q;
   logic        out_valid_q;

   logic        take;
   logic [3:0]  take_code;
   logic        fifo_busy;

`ifdef DECODER_FIFO_EN
   logic [3:0] mem [0:1];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic [1:0] count_next;
   logic       ready_q;
   logic       push;
   logic       pop;

   assign push      = bus.in_valid && ready_q;
   // A code may leave the FIFO whenever the output is not mid-pulse.
   assign pop       = ((state == IDLE) || (state == GAP)) && (count != 2'd0);
   assign take      = pop;
   assign take_code = mem[rd_ptr];
   assign fifo_busy = (count != 2'd0);

   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + 2'd1;
      end else if (pop && !push) begin
         count_next = count - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= 2'd0;
         ready_q <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count   <= count_next;
         ready_q <= (count_next != 2'd2);
      end
   end

   // Storage needs no reset: occupancy alone says which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.in_code;
      end
   end

   assign bus.in_ready = ready_q;
`else
   assign take         = bus.in_valid && (state == IDLE);
   assign take_code    = bus.in_code;
   assign fifo_busy    = 1'b0;
   assign bus.in_ready = (state == IDLE);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         out_q       <= 16'h0000;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE, GAP: begin
               if (take) begin
                  state       <= HOLD;
                  cnt         <= CNT_LOAD;
                  out_q       <= 16'h0001 << take_code;
                  out_valid_q <= 1'b1;
               end else begin
                  state       <= IDLE;
                  out_q       <= 16'h0000;
                  out_valid_q <= 1'b0;
               end
            end
            HOLD: begin
               if (cnt == 8'd0) begin
                  state       <= GAP;
                  out_q       <= 16'h0000;
                  out_valid_q <= 1'b0;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            default: begin
               state       <= IDLE;
               cnt         <= 8'd0;
               out_q       <= 16'h0000;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = (state != IDLE) || fifo_busy;
   assign state_dbg     = state;

endmodule

// File: tb/tb_one_hot_pulse_decoder.sv
// Bench for one_hot_pulse_decoder: two instances (HOLD_CYCLES 4 and 1) against a
// timeline model that schedules each accepted code's pulse window arithmetically.
module tb_one_hot_pulse_decoder;

   localparam int MAXC = 2048;
   localparam int H0   = 4;
   localparam int H1   = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   one_hot_pulse_decoder_if b0 ();
   one_hot_pulse_decoder_if b1 ();
   logic [1:0] sd0;
   logic [1:0] sd1;

   one_hot_pulse_decoder #(.HOLD_CYCLES(H0)) dut0 (
      .clk       (clk),
      .rst       (rst),
      .bus       (b0),
      .state_dbg (sd0)
   );

   one_hot_pulse_decoder #(.HOLD_CYCLES(H1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .bus       (b1),
      .state_dbg (sd1)
   );

   // cyc = number of rising edges seen; cycle k is the period after edge k.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_total = 0;
   int n_pass  = 0;

   // Expected timeline per instance.
   logic [15:0] exp_out  [0:1][0:MAXC-1];
   bit          exp_busy [0:1][0:MAXC-1];
   int          ready_from [0:1];
   int          prev_end   [0:1];
   int          last_start [0:1];
   int          acc_push   [0:1][0:MAXC-1];
   int          acc_pop    [0:1][0:MAXC-1];
   int          n_acc      [0:1];

   function automatic int hold_of(input int d);
      return (d == 0) ? H0 : H1;
   endfunction

   function automatic bit exp_ready(input int d, input int k);
`ifdef DECODER_FIFO_EN
      int occ;
      occ = 0;
      for (int i = n_acc[d] - 3; i < n_acc[d]; i++) begin
         if (i >= 0 && acc_push[d][i] <= k && acc_pop[d][i] > k) occ++;
      end
      return (occ < 2);
`else
      return (k >= ready_from[d]);
`endif
   endfunction

   // Code c transferred at edge n: pulse occupies cycles s..s+h-1, gap at s+h.
   task automatic model_accept(input int d, input logic [3:0] c, input int n);
      int h;
      int s;
      logic [15:0] line;
      h    = hold_of(d);
      line = 16'h0001;
      line = line << c;
`ifdef DECODER_FIFO_EN
      s = (n + 1 > prev_end[d] + 2) ? n + 1 : prev_end[d] + 2;
      acc_push[d][n_acc[d]] = n;
      acc_pop[d][n_acc[d]]  = s;
      n_acc[d]++;
`else
      s = n;
      ready_from[d] = n + h + 1;
`endif
      prev_end[d]   = s + h - 1;
      last_start[d] = s;
      for (int k = s; k < s + h; k++) if (k < MAXC) exp_out[d][k] = line;
      for (int k = n; k <= s + h; k++) if (k < MAXC) exp_busy[d][k] = 1'b1;
   endtask

   task automatic model_reset(input int from);
      for (int d = 0; d < 2; d++) begin
         for (int k = from; k < MAXC; k++) begin
            exp_out[d][k]  = 16'h0000;
            exp_busy[d][k] = 1'b0;
         end
         ready_from[d] = 0;
         prev_end[d]   = -100;
         n_acc[d]      = 0;
      end
   endtask

   task automatic chk(input string tag, input int d, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s dut%0d cyc %0d: observed %h expected %h", tag, d, cyc, got, exp);
   endtask

   task automatic check_dut(input int d, input logic [15:0] o, input logic ov,
                            input logic rdy, input logic bz);
      chk("out",       d, o,               exp_out[d][cyc]);
      chk("out_valid", d, 16'(ov),         16'(exp_out[d][cyc] != 16'h0000));
      chk("in_ready",  d, 16'(rdy),        16'(exp_ready(d, cyc)));
      chk("busy",      d, 16'(bz),         16'(exp_busy[d][cyc]));
      chk("onehot0",   d, 16'($onehot0(o)), 16'd1);
   endtask

   task automatic check_reset();
      chk("rst_out",       0, b0.out,            16'h0000);
      chk("rst_out_valid", 0, 16'(b0.out_valid), 16'd0);
      chk("rst_in_ready",  0, 16'(b0.in_ready),  16'd1);
      chk("rst_busy",      0, 16'(b0.busy),      16'd0);
      chk("rst_out",       1, b1.out,            16'h0000);
      chk("rst_out_valid", 1, 16'(b1.out_valid), 16'd0);
      chk("rst_in_ready",  1, 16'(b1.in_ready),  16'd1);
      chk("rst_busy",      1, 16'(b1.busy),      16'd0);
   endtask

   // One cycle: check current outputs, then drive inputs for the next edge.
   task automatic step(input logic v0, input logic [3:0] c0, input logic v1, input logic [3:0] c1,
                       output bit a0, output bit a1);
      @(negedge clk);
      check_dut(0, b0.out, b0.out_valid, b0.in_ready, b0.busy);
      check_dut(1, b1.out, b1.out_valid, b1.in_ready, b1.busy);
      b0.in_valid = v0;
      b0.in_code  = c0;
      b1.in_valid = v1;
      b1.in_code  = c1;
      a0 = v0 && exp_ready(0, cyc);
      a1 = v1 && exp_ready(1, cyc);
      if (a0) model_accept(0, c0, cyc + 1);
      if (a1) model_accept(1, c1, cyc + 1);
   endtask

   task automatic idle(input int n);
      bit a0;
      bit a1;
      for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 4'h0, a0, a1);
   endtask

   // Present c to both instances (valid held) until each has taken it.
   task automatic send(input logic [3:0] c);
      bit p0;
      bit p1;
      bit a0;
      bit a1;
      int guard;
      p0 = 1'b1;
      p1 = 1'b1;
      guard = 0;
      while ((p0 || p1) && guard < 40) begin
         step(p0, c, p1, c, a0, a1);
         if (a0) p0 = 1'b0;
         if (a1) p1 = 1'b0;
         guard++;
      end
      n_total++;
      assert (!p0 && !p1) n_pass++;
      else $error("FAIL send_timeout code %0d: observed pending %0b%0b expected 00", c, p0, p1);
   endtask

   initial begin
      bit a0;
      bit a1;
      int guard;
      logic [3:0] code;

      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < MAXC; k++) begin
            exp_out[d][k]  = 16'h0000;
            exp_busy[d][k] = 1'b0;
         end
      end
      model_reset(0);
      b0.in_valid = 1'b0;
      b0.in_code  = 4'h0;
      b1.in_valid = 1'b0;
      b1.in_code  = 4'h0;

      // Asynchronous reset before any clock edge.
      rst = 1'b0;
      #1 rst = 1'b1;
      #2 check_reset();
      @(negedge clk);
      rst = 1'b0;
      model_reset(cyc);

      // Single code 4'hA, then let it drain.
      idle(2);
      send(4'hA);
      idle(8);

      // Sweep all codes back to back.
      for (int c = 0; c < 16; c++) send(4'(c));
      idle(8);

      // Random valid/code, independent per instance.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a0, a1);
      end
      idle(10);

      // Reset in the second HOLD cycle of code 3 on the HOLD_CYCLES=4 instance.
      send(4'h3);
      guard = 0;
      while (cyc != last_start[0] + 1 && guard < 20) begin
         idle(1);
         guard++;
      end
      n_total++;
      assert (cyc == last_start[0] + 1) n_pass++;
      else $error("FAIL reset_window: observed cyc %0d expected %0d", cyc, last_start[0] + 1);
      #2 rst = 1'b1;
      model_reset(cyc);
      #1 check_reset();
      @(negedge clk);
      rst = 1'b0;
      model_reset(cyc);
      idle(8);

      // Back-to-back codes 1, 2, 3 with valid held.
      for (int i = 1; i <= 3; i++) begin
         code = 4'(i);
         send(code);
      end
      idle(14);

      // Extremes on the single-cycle instance (and the 4-cycle one alongside).
      send(4'h0);
      send(4'hF);
      idle(10);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/one_hot_pulse_decoder.md
# one_hot_pulse_decoder

Sequential 4-to-16 decoder: the inverse of the team's 16-to-4 priority encoder. It accepts a 4-bit line index over a valid/ready handshake and drives the matching one-hot output line for a parameterised number of cycles. A mandatory dead cycle follows each pulse (break-before-make). It sits on the driving side of any bus whose far end is priority-encoded back to an index.

## Interface
- HOLD_CYCLES, default 4: cycles each decoded line stays asserted; legal range 1..255; internal hold counter is 8 bits.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_code is presented.
- in_ready  output  1  block can accept in_code this cycle.
- in_code  input  4  line index 0..15.
- out  output  16  one-hot decoded lines (registered); all-zero when no pulse is active.
- out_valid  output  1  high exactly while out is non-zero.
- busy  output  1  high whenever state ≠ IDLE or a code is buffered.

## Operation
- Decode rule: code c drives out[c] = 1 and all other bits 0. Never more than one bit set; never glitches between codes.
- FSM states:
  - IDLE: out = 0.
  - HOLD: out = 1 << latched code; counter loads HOLD_CYCLES-1 and decrements each cycle.
  - GAP: exactly 1 cycle, out = 0.
- Transitions:
  - IDLE → HOLD when a code is taken (handshake, or FIFO pop).
  - HOLD → GAP when the counter is 0.
  - GAP → HOLD when a code is available (FIFO build only).
  - GAP → IDLE otherwise.
- Handshake: transfer occurs when in_valid && in_ready at a rising edge. in_code is sampled only on transfer. in_valid without in_ready is ignored with no side effects.
- Base build: in_ready = (state == IDLE), combinational from state.
- Reset (asynchronous, any time including mid-HOLD): state IDLE, out 16'h0000, out_valid 0, counter 0, FIFO empty, busy 0, in_ready 1. Outputs clear immediately on rst assertion, not at the next edge.

## Timing
- Base build latency: transfer at edge N → out valid during cycle after edge N (N+1 .. N+HOLD_CYCLES) → GAP at cycle N+HOLD_CYCLES+1 → in_ready high again from cycle N+HOLD_CYCLES+2.
- Base throughput: one code per HOLD_CYCLES+2 cycles.
- HOLD_CYCLES = 1: a single-cycle pulse, then GAP.
- out and out_valid are flops; no combinational path from in_* to out.

## Configuration
- DECODER_FIFO_EN defined:
  - Adds a 2-entry input FIFO; in_ready = !full, registered.
  - Codes are accepted during HOLD and GAP.
  - IDLE with FIFO non-empty: pop and go to HOLD; out appears the cycle after the pop, so latency from transfer into an empty FIFO is 2 cycles.
  - At the end of GAP with FIFO non-empty: pop and go directly to HOLD; throughput is one code per HOLD_CYCLES+1 cycles.
  - Push and pop in the same cycle are legal at occupancy 1.
  - At occupancy 2, in_ready is 0 and no push occurs.
  - FIFO order is strict first-in, first-out.
- DECODER_FIFO_EN undefined: no FIFO storage; behaviour exactly as the base build above.

## Test plan
- Reset, then in_code=4'hA with in_valid pulsed, HOLD_CYCLES=4 → out=16'h0400 for 4 cycles starting 1 cycle after transfer, then 1 cycle 16'h0000, then in_ready=1.
- Sweep codes 0..15 (base build) → out equals 1<<c each time, out_valid tracks out≠0, never two bits set, one GAP cycle of zeros between pulses.
- Hold in_valid high during HOLD (base build) → in_ready=0, code not captured, no change to out; code captured on return to IDLE.
- Assert rst in the 2nd HOLD cycle of code 4'h3 → out=0, out_valid=0, in_ready=1 immediately; no resumption after rst release.
- DECODER_FIFO_EN, back-to-back codes 1, 2, 3 → in_ready drops after 2 buffered; pulses 16'h0002, 16'h0004, 16'h0008 each separated by exactly one zero cycle.
- HOLD_CYCLES=1, codes 0 and 15 → single-cycle pulses 16'h0001 and 16'h8000 with one zero cycle between.
